ccx_emem_arbiter: RTL

//  Two-requester arbiter sharing the core complex external memory port (emem_*).

---
 rtl/ccx_emem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ccx_emem_arbiter.sv
// Two-requester arbiter for the core complex external memory port.
// Owns one emem transaction at a time and returns its response (or a timeout error) to the requester that was granted.
module ccx_emem_arbiter #(
  parameter int AW             = 39,
  parameter int DW             = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            r0_req,
  input  logic            r0_rtype,
  input  logic [AW-1:0]   r0_addr,
  input  logic            r0_wen,
  input  logic [DW/8-1:0] r0_strb,
  input  logic [DW-1:0]   r0_wdata,
  output logic            r0_gnt,
  output logic            r0_err,
  output logic [DW-1:0]   r0_rdata,

  input  logic            r1_req,
  input  logic            r1_rtype,
  input  logic [AW-1:0]   r1_addr,
  input  logic            r1_wen,
  input  logic [DW/8-1:0] r1_strb,
  input  logic [DW-1:0]   r1_wdata,
  output logic            r1_gnt,
  output logic            r1_err,
  output logic [DW-1:0]   r1_rdata,

  output logic            emem_req,
  output logic            emem_rtype,
  output logic [AW-1:0]   emem_addr,
  output logic            emem_wen,
  output logic [DW/8-1:0] emem_strb,
  output logic [DW-1:0]   emem_wdata,
  input  logic            emem_gnt,
  input  logic            emem_err,
  input  logic [DW-1:0]   emem_rdata,

  output logic            timeout
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic          rtype;
    logic [AW-1:0] addr;
    logic          wen;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          emem_req_q, emem_req_d;
  req_t          req_q, req_d;
  logic [CW-1:0] count_q, count_d;

  req_t          in0, in1;
  logic          win;
  logic          resp_vld;
  logic          resp_err;
  logic [DW-1:0] resp_rdata;
  logic          to_pulse;

  assign in0 = '{rtype: r0_rtype, addr: r0_addr, wen: r0_wen, strb: r0_strb, wdata: r0_wdata};
  assign in1 = '{rtype: r1_rtype, addr: r1_addr, wen: r1_wen, strb: r1_strb, wdata: r1_wdata};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    emem_req_d = emem_req_q;
    req_d      = req_q;
    count_d    = count_q;
    win        = 1'b0;
    resp_vld   = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    to_pulse   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie the port that did not win last time goes first.
          win        = (r0_req && r1_req) ? ~last_q : r1_req;
          owner_d    = win;
          last_d     = win;
          req_d      = win ? in1 : in0;
          emem_req_d = 1'b1;
          count_d    = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        count_d = count_q + 1'b1;
        if (emem_gnt) begin
          resp_vld   = 1'b1;
          resp_err   = emem_err;
          resp_rdata = emem_rdata;
          emem_req_d = 1'b0;
          state_d    = IDLE;
        end else if (TO_EN && (count_q == TO_LAST)) begin
          resp_vld   = 1'b1;
          resp_err   = 1'b1;
          to_pulse   = 1'b1;
          emem_req_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      emem_req_q <= 1'b0;
      req_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      emem_req_q <= emem_req_d;
      req_q      <= req_d;
      count_q    <= count_d;
    end
  end

  assign emem_req   = emem_req_q;
  assign emem_rtype = req_q.rtype;
  assign emem_addr  = req_q.addr;
  assign emem_wen   = req_q.wen;
  assign emem_strb  = req_q.strb;
  assign emem_wdata = req_q.wdata;

  assign r0_gnt   = resp_vld & ~owner_q;
  assign r0_err   = resp_err & ~owner_q;
  assign r0_rdata = owner_q ? '0 : resp_rdata;
  assign r1_gnt   = resp_vld & owner_q;
  assign r1_err   = resp_err & owner_q;
  assign r1_rdata = owner_q ? resp_rdata : '0;
  assign timeout  = to_pulse;

endmodule
